// File: rtl/cpu_oci_trace_monitor.sv
// Trace capture monitor: a session FSM feeds a first-word-fall-through FIFO of trace words.
// Define OCI_TRACE_TIMESTAMP_EN to store a free-running 16-bit timestamp with each entry.
module cpu_oci_trace_monitor #(
  parameter int DATA_W  = 30,
  parameter int COUNT_W = 4,
  parameter int DEPTH   = 16,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  dct_buffer,
  input  logic [COUNT_W-1:0] dct_count,
  input  logic               dct_valid,
  input  logic               arm,
  input  logic               test_ending,
  input  logic               test_has_ended,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic [COUNT_W-1:0] rd_count,
  output logic [15:0]        rd_timestamp,
  output logic [LVL_W-1:0]   level,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [15:0]        drop_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]   level_reg, level_next;
  logic               overflow_reg;
  logic [15:0]        drop_count_reg;

  logic [DATA_W-1:0]  mem_data  [DEPTH];
  logic [COUNT_W-1:0] mem_count [DEPTH];

  logic push_req, push, pop, full, drop, rearm;

  assign full     = (level_reg == LVL_W'(DEPTH));
  assign pop      = (level_reg != '0) && rd_ready;
  assign push_req = (state_reg == CAPTURE) && dct_valid && (dct_count != '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign rearm    = (state_reg == DONE) && arm && !test_has_ended;

  always_comb begin
    level_next = level_reg;
    if (push && !pop)
      level_next = level_reg + LVL_W'(1);
    else if (!push && pop)
      level_next = level_reg - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arm) state_next = CAPTURE;
      CAPTURE: begin
        if (test_has_ended)   state_next = DONE;
        else if (test_ending) state_next = DRAIN;
      end
      DRAIN:   if (test_has_ended || level_next == '0) state_next = DONE;
      DONE:    if (rearm) state_next = CAPTURE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else if (rearm) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 16'hFFFF)
          drop_count_reg <= drop_count_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_reg]  <= dct_buffer;
      mem_count[wr_ptr_reg] <= dct_count;
    end
  end

`ifdef OCI_TRACE_TIMESTAMP_EN
  logic [15:0] ts_reg;
  logic [15:0] mem_ts [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ts_reg <= '0;
    else
      ts_reg <= ts_reg + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_ts[wr_ptr_reg] <= ts_reg;
  end

  assign rd_timestamp = mem_ts[rd_ptr_reg];
`else
  assign rd_timestamp = '0;
`endif

  assign rd_valid   = (level_reg != '0);
  assign rd_data    = mem_data[rd_ptr_reg];
  assign rd_count   = mem_count[rd_ptr_reg];
  assign level      = level_reg;
  assign busy       = (state_reg == CAPTURE) || (state_reg == DRAIN);
  assign done       = (state_reg == DONE);
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_cpu_oci_trace_monitor.sv
// Self-checking bench for cpu_oci_trace_monitor: vector table, corner sequences and
// randomized traffic against a queue-based session model.
module tb_cpu_oci_trace_monitor;
  localparam int DATA_W  = 30;
  localparam int COUNT_W = 4;
  localparam int DEPTH   = 16;
  localparam int LVL_W   = 5;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic [DATA_W-1:0]  dct_buffer = '0;
  logic [COUNT_W-1:0] dct_count = '0;
  logic               dct_valid = 1'b0;
  logic               arm = 1'b0;
  logic               test_ending = 1'b0;
  logic               test_has_ended = 1'b0;
  logic               rd_ready = 1'b0;
  logic               rd_valid;
  logic [DATA_W-1:0]  rd_data;
  logic [COUNT_W-1:0] rd_count;
  logic [15:0]        rd_timestamp;
  logic [LVL_W-1:0]   level;
  logic               busy, done, overflow;
  logic [15:0]        drop_count;

  always #5 clk = ~clk;

  cpu_oci_trace_monitor #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .arm(arm), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_count(rd_count), .rd_timestamp(rd_timestamp), .level(level),
    .busy(busy), .done(done), .overflow(overflow), .drop_count(drop_count)
  );

  // Reference model: session mode plus a queue of captured entries.
  typedef enum {M_IDLE, M_CAP, M_DRAIN, M_DONE} mode_t;
  typedef struct {
    logic [3:0]  cnt;
    logic [29:0] data;
    logic [15:0] ts;
  } ent_t;

  ent_t  q[$];
  mode_t m_mode = M_IDLE;
  bit    m_ovf = 0;
  int    m_drop = 0;
  int    m_time = 0;
  int    passed = 0;
  int    total = 0;

  typedef struct {
    bit          a, te, the, dv, rr;
    logic [3:0]  cnt;
    logic [29:0] data;
    int          e_level;
    bit          e_valid, e_busy, e_done;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(bit a, bit te, bit the, bit dv, bit rr, logic [3:0] cnt,
                              logic [29:0] data, int lvl, bit v, bit b, bit d);
    vec_t r;
    r.a = a; r.te = te; r.the = the; r.dv = dv; r.rr = rr; r.cnt = cnt; r.data = data;
    r.e_level = lvl; r.e_valid = v; r.e_busy = b; r.e_done = d;
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_update(input bit a, te, the, dv, rr, input logic [3:0] cnt,
                              input logic [29:0] data);
    bit pop, push, rearm;
    ent_t e;
    pop   = (q.size() != 0) && rr;
    push  = (m_mode == M_CAP) && dv && (cnt != 0);
    rearm = (m_mode == M_DONE) && a && !the;
    e.cnt = cnt; e.data = data; e.ts = 16'(m_time);
    if (rearm) begin
      q.delete(); m_ovf = 0; m_drop = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(e);
        else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
    case (m_mode)
      M_IDLE:  if (a) m_mode = M_CAP;
      M_CAP:   if (the) m_mode = M_DONE; else if (te) m_mode = M_DRAIN;
      M_DRAIN: if (the || q.size() == 0) m_mode = M_DONE;
      M_DONE:  if (rearm) m_mode = M_CAP;
      default: ;
    endcase
    m_time = (m_time + 1) % 65536;
  endtask

  task automatic compare_model();
    chk("level", level, q.size());
    chk("rd_valid", rd_valid, q.size() != 0);
    chk("busy", busy, (m_mode == M_CAP) || (m_mode == M_DRAIN));
    chk("done", done, m_mode == M_DONE);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drop);
    if (q.size() != 0) begin
      chk("rd_data", rd_data, q[0].data);
      chk("rd_count", rd_count, q[0].cnt);
`ifdef OCI_TRACE_TIMESTAMP_EN
      chk("rd_timestamp", rd_timestamp, q[0].ts);
`endif
    end
`ifndef OCI_TRACE_TIMESTAMP_EN
    chk("rd_timestamp_zero", rd_timestamp, 0);
`endif
  endtask

  task automatic step(input bit a, te, the, dv, rr, input logic [3:0] cnt,
                      input logic [29:0] data);
    arm = a; test_ending = te; test_has_ended = the; dct_valid = dv; rd_ready = rr;
    dct_count = cnt; dct_buffer = data;
    model_update(a, te, the, dv, rr, cnt, data);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  // Asserts reset between clock edges so the clear is observed asynchronously.
  task automatic do_reset();
    arm = 0; test_ending = 0; test_has_ended = 0; dct_valid = 0; rd_ready = 0;
    dct_count = '0; dct_buffer = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
    q.delete(); m_mode = M_IDLE; m_ovf = 0; m_drop = 0; m_time = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] t1, t2;
    int rr_pct;

    vecs[0]  = mk(1,0,0,0,0, 4'd0, 30'h0,   0,0,1,0);
    vecs[1]  = mk(0,0,0,1,0, 4'd3, 30'h155, 1,1,1,0);
    vecs[2]  = mk(0,0,0,1,0, 4'd0, 30'h3,   1,1,1,0);
    vecs[3]  = mk(0,0,0,0,0, 4'd5, 30'h4,   1,1,1,0);
    vecs[4]  = mk(0,0,0,1,0, 4'd1, 30'h0AA, 2,1,1,0);
    vecs[5]  = mk(0,0,0,1,0, 4'd2, 30'h3FF, 3,1,1,0);
    vecs[6]  = mk(1,0,0,1,0, 4'd4, 30'h123, 4,1,1,0);
    vecs[7]  = mk(0,1,0,1,0, 4'd5, 30'h456, 5,1,1,0);
    vecs[8]  = mk(0,0,0,1,0, 4'd7, 30'h789, 5,1,1,0);
    vecs[9]  = mk(1,0,0,0,1, 4'd0, 30'h0,   4,1,1,0);
    vecs[10] = mk(0,0,0,0,1, 4'd0, 30'h0,   3,1,1,0);
    vecs[11] = mk(0,0,0,0,1, 4'd0, 30'h0,   2,1,1,0);
    vecs[12] = mk(0,0,0,0,1, 4'd0, 30'h0,   1,1,1,0);
    vecs[13] = mk(0,0,0,0,1, 4'd0, 30'h0,   0,0,0,1);
    vecs[14] = mk(0,0,0,1,1, 4'd2, 30'h5,   0,0,0,1);
    vecs[15] = mk(1,0,0,0,0, 4'd0, 30'h0,   0,0,1,0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].a, vecs[i].te, vecs[i].the, vecs[i].dv, vecs[i].rr, vecs[i].cnt, vecs[i].data);
      chk("vec_level", level, vecs[i].e_level);
      chk("vec_rd_valid", rd_valid, vecs[i].e_valid);
      chk("vec_busy", busy, vecs[i].e_busy);
      chk("vec_done", done, vecs[i].e_done);
      if (i == 1) begin
        chk("vec_first_count", rd_count, 3);
        chk("vec_first_data", rd_data, 30'h155);
      end
      $display("vec %0d: arm=%0b te=%0b the=%0b dv=%0b rr=%0b cnt=%0d -> level=%0d busy=%0b done=%0b",
               i, vecs[i].a, vecs[i].te, vecs[i].the, vecs[i].dv, vecs[i].rr, vecs[i].cnt,
               level, busy, done);
    end

    // Fill past full, drain in order, then hard stop and rearm clears the sticky status.
    do_reset();
    step(1,0,0,0,0, 4'd0, 30'h0);
    for (int i = 0; i < 18; i++) step(0,0,0,1,0, 4'(i % 15 + 1), 30'(i * 3 + 7));
    chk("fill_level", level, 16);
    chk("fill_overflow", overflow, 1);
    chk("fill_drop_count", drop_count, 2);
    for (int i = 0; i < 16; i++) begin
      chk("fill_order", rd_data, 30'(i * 3 + 7));
      step(0,0,0,0,1, 4'd0, 30'h0);
    end
    chk("fill_empty", rd_valid, 0);
    step(0,0,1,0,0, 4'd0, 30'h0);
    chk("fill_hard_done", done, 1);
    step(1,0,0,0,0, 4'd0, 30'h0);
    chk("rearm_overflow", overflow, 0);
    chk("rearm_drop_count", drop_count, 0);
    $display("fill: 18 pushed, 16 drained, rearm overflow=%0b drop_count=%0d", overflow, drop_count);

    // Push and pop together while full.
    do_reset();
    step(1,0,0,0,0, 4'd0, 30'h0);
    for (int i = 0; i < 16; i++) step(0,0,0,1,0, 4'd1, 30'(100 + i));
    step(0,0,0,1,1, 4'd9, 30'h2AAA);
    chk("full_simul_level", level, 16);
    chk("full_simul_overflow", overflow, 0);
    chk("full_simul_head", rd_data, 30'd101);
    $display("full+simul: level=%0d overflow=%0b", level, overflow);

    // Hard stop with 4 queued, partial pop, then rearm empties the FIFO.
    do_reset();
    step(1,0,0,0,0, 4'd0, 30'h0);
    for (int i = 0; i < 4; i++) step(0,0,0,1,0, 4'd2, 30'(200 + i));
    step(1,1,1,0,0, 4'd0, 30'h0);
    chk("hard_done", done, 1);
    chk("hard_busy", busy, 0);
    chk("hard_level", level, 4);
    for (int i = 0; i < 2; i++) begin
      chk("hard_pop_data", rd_data, 30'(200 + i));
      step(0,0,0,0,1, 4'd0, 30'h0);
    end
    step(1,0,0,0,0, 4'd0, 30'h0);
    chk("hard_rearm_level", level, 0);
    chk("hard_rearm_busy", busy, 1);
    $display("hard stop: rearm level=%0d busy=%0b", level, busy);

    // Two pushes seven cycles apart.
    do_reset();
    step(1,0,0,0,0, 4'd0, 30'h0);
    step(0,0,0,1,0, 4'd1, 30'h11);
    for (int i = 0; i < 6; i++) step(0,0,0,0,0, 4'd0, 30'h0);
    step(0,0,0,1,0, 4'd1, 30'h22);
    t1 = rd_timestamp;
    step(0,0,0,0,1, 4'd0, 30'h0);
    t2 = rd_timestamp;
`ifdef OCI_TRACE_TIMESTAMP_EN
    chk("ts_delta", 16'(t2 - t1), 7);
`else
    chk("ts_first_zero", t1, 0);
    chk("ts_second_zero", t2, 0);
`endif
    $display("timestamp: first=%0d second=%0d", t1, t2);

    // Randomized sessions, with a mid-run reset to discard live contents.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        step(0,0,0,1,0, 4'd3, 30'h1);
      end
      rr_pct = ((i / 250) % 2 != 0) ? 15 : 60;
      step($urandom_range(99) < 4, $urandom_range(99) < 2, $urandom_range(99) < 1,
           $urandom_range(99) < 70, $urandom_range(99) < rr_pct,
           4'($urandom_range(15)), 30'($urandom));
    end
    $display("random: 3000 cycles, final level=%0d drop_count=%0d", level, drop_count);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
